gb_cpu_alu16_seq: RTL and testbench

- Sequencer that performs 16-bit arithmetic (ADD HL,rr / ADD SP,e8 / LD HL,SP+e8 / INC rr / DEC rr) by driving the shared 8-bit CPU ALU for two consecutive cycles: low byte first, then high byte with carry/borrow.
- Sits between the CPU control unit and the 8-bit ALU. While busy it owns the ALU instruction and flag inputs. While idle it drives ALU_NOP.
- Produces a registered 16-bit result and the final Game Boy flag set.

---
 rtl/gb_cpu_alu16_seq.sv | 212 +++++++++++++++++++++
 tb/tb_gb_cpu_alu16_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gb_cpu_alu16_seq.sv
// 16-bit ADD/INC/DEC sequencer for the SM83 core: runs the shared 8-bit ALU
// over two cycles (low byte, then high byte with carry) and registers result and flags.
package gb_cpu_alu16_pkg;
    typedef struct packed {
        logic z;
        logic n;
        logic h;
        logic c;
    } alu_flags_t;

    typedef enum logic [2:0] {
        ALU_NOP = 3'd0,
        ALU_ADD = 3'd1,
        ALU_ADC = 3'd2,
        ALU_SUB = 3'd3,
        ALU_SBC = 3'd4
    } alu_op_t;

    typedef struct packed {
        alu_op_t    op;
        logic [7:0] a;
        logic [7:0] b;
    } alu_instruction_t;
endpackage

module gb_cpu_alu16_seq
    import gb_cpu_alu16_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [15:0]      operand_a,
    input  logic [15:0]      operand_b,
    input  alu_flags_t       flags_i,
    output alu_instruction_t alu_instr_o,
    output alu_flags_t       alu_flags_o,
    input  logic [7:0]       alu_out_i,
    input  alu_flags_t       alu_flags_i,
    output logic             busy,
    output logic             done,
    output logic [15:0]      result,
    output alu_flags_t       flags_o
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    localparam logic [1:0] OP_ADD16   = 2'b00;
    localparam logic [1:0] OP_ADDSPE8 = 2'b01;
    localparam logic [1:0] OP_INC16   = 2'b10;
    localparam logic [1:0] OP_DEC16   = 2'b11;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [15:0]      a_q, a_d;
    logic [15:0]      b_q, b_d;
    alu_flags_t       fcap_q, fcap_d;
    logic [7:0]       res_lo_q, res_lo_d;
    logic             h_lo_q, h_lo_d;
    logic             c_lo_q, c_lo_d;
    logic [15:0]      result_q, result_d;
    alu_flags_t       flags_q, flags_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    alu_instruction_t alu_instr_s;
    alu_flags_t       alu_flags_s;
    logic             unused_s;

    // Next-state, operand capture and ALU drive for each byte phase.
    always_comb begin
        state_d            = state_q;
        op_d               = op_q;
        a_d                = a_q;
        b_d                = b_q;
        fcap_d             = fcap_q;
        res_lo_d           = res_lo_q;
        h_lo_d             = h_lo_q;
        c_lo_d             = c_lo_q;
        result_d           = result_q;
        flags_d            = flags_q;
        busy_d             = 1'b0;
        done_d             = 1'b0;
        alu_instr_s.op     = ALU_NOP;
        alu_instr_s.a      = 8'h00;
        alu_instr_s.b      = 8'h00;
        alu_flags_s        = 4'b0000;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LO;
                    op_d    = op;
                    a_d     = operand_a;
                    b_d     = operand_b;
                    fcap_d  = flags_i;
                    busy_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LO: begin
                alu_flags_s   = fcap_q;
                alu_flags_s.c = 1'b0;
                alu_instr_s.a = a_q[7:0];
                case (op_q)
                    OP_ADD16, OP_ADDSPE8: begin
                        alu_instr_s.op = ALU_ADD;
                        alu_instr_s.b  = b_q[7:0];
                    end
                    OP_INC16: begin
                        alu_instr_s.op = ALU_ADD;
                        alu_instr_s.b  = 8'h01;
                    end
                    default: begin
                        alu_instr_s.op = ALU_SUB;
                        alu_instr_s.b  = 8'h01;
                    end
                endcase
                res_lo_d = alu_out_i;
                h_lo_d   = alu_flags_i.h;
                c_lo_d   = alu_flags_i.c;
                state_d  = S_HI;
                busy_d   = 1'b1;
            end
            S_HI: begin
                alu_flags_s   = fcap_q;
                alu_flags_s.c = c_lo_q;
                alu_instr_s.a = a_q[15:8];
                case (op_q)
                    OP_ADD16: begin
                        alu_instr_s.op = ALU_ADC;
                        alu_instr_s.b  = b_q[15:8];
                        flags_d.z      = fcap_q.z;
                        flags_d.n      = 1'b0;
                        flags_d.h      = alu_flags_i.h;
                        flags_d.c      = alu_flags_i.c;
                    end
                    OP_ADDSPE8: begin
                        // e8 is signed: the high byte adds its sign extension
                        alu_instr_s.op = ALU_ADC;
                        alu_instr_s.b  = {8{b_q[7]}};
                        flags_d.z      = 1'b0;
                        flags_d.n      = 1'b0;
                        flags_d.h      = h_lo_q;
                        flags_d.c      = c_lo_q;
                    end
                    OP_INC16: begin
                        alu_instr_s.op = ALU_ADC;
                        alu_instr_s.b  = 8'h00;
                        flags_d        = fcap_q;
                    end
                    default: begin
                        alu_instr_s.op = ALU_SBC;
                        alu_instr_s.b  = 8'h00;
                        flags_d        = fcap_q;
                    end
                endcase
                result_d = {alu_out_i, res_lo_q};
                state_d  = S_FIN;
                done_d   = 1'b1;
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= 2'b00;
            a_q      <= 16'h0000;
            b_q      <= 16'h0000;
            fcap_q   <= 4'b0000;
            res_lo_q <= 8'h00;
            h_lo_q   <= 1'b0;
            c_lo_q   <= 1'b0;
            result_q <= 16'h0000;
            flags_q  <= 4'b0000;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            fcap_q   <= fcap_d;
            res_lo_q <= res_lo_d;
            h_lo_q   <= h_lo_d;
            c_lo_q   <= c_lo_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign alu_instr_o = alu_instr_s;
    assign alu_flags_o = alu_flags_s;
    assign busy        = busy_q;
    assign done        = done_q;
    assign result      = result_q;
    assign flags_o     = flags_q;
    assign unused_s    = ^{alu_flags_i.z, alu_flags_i.n};
endmodule

// File: tb/tb_gb_cpu_alu16_seq.sv
// Bench for gb_cpu_alu16_seq: a behavioural 8-bit ALU closes the loop, a driver
// queues expected results and a done-triggered monitor checks them.
module tb_gb_cpu_alu16_seq;
    import gb_cpu_alu16_pkg::*;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  fl;
        int          acc;
    } exp_t;

    logic             clk;
    logic             reset;
    logic             start;
    logic [1:0]       op;
    logic [15:0]      operand_a;
    logic [15:0]      operand_b;
    alu_flags_t       flags_i;
    alu_instruction_t alu_instr_o;
    alu_flags_t       alu_flags_o;
    logic [7:0]       alu_out_i;
    alu_flags_t       alu_flags_i;
    logic             busy;
    logic             done;
    logic [15:0]      result;
    alu_flags_t       flags_o;

    exp_t exp_q[$];
    int   cyc = 0;
    int   next_free = 0;
    int   checks = 0;
    int   errors = 0;

    logic [8:0] t9;
    logic [4:0] t5;
    logic       cin;

    gb_cpu_alu16_seq dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .flags_i    (flags_i),
        .alu_instr_o(alu_instr_o),
        .alu_flags_o(alu_flags_o),
        .alu_out_i  (alu_out_i),
        .alu_flags_i(alu_flags_i),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .flags_o    (flags_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SM83 8-bit ALU for the operations the sequencer issues.
    always_comb begin
        t9          = 9'h000;
        t5          = 5'h00;
        cin         = 1'b0;
        alu_out_i   = 8'h00;
        alu_flags_i = alu_flags_o;
        case (alu_instr_o.op)
            ALU_ADD, ALU_ADC: begin
                cin = (alu_instr_o.op == ALU_ADC) ? alu_flags_o.c : 1'b0;
                t9  = {1'b0, alu_instr_o.a} + {1'b0, alu_instr_o.b} + {8'h00, cin};
                t5  = {1'b0, alu_instr_o.a[3:0]} + {1'b0, alu_instr_o.b[3:0]} + {4'h0, cin};
                alu_out_i     = t9[7:0];
                alu_flags_i.z = (t9[7:0] == 8'h00);
                alu_flags_i.n = 1'b0;
                alu_flags_i.h = t5[4];
                alu_flags_i.c = t9[8];
            end
            ALU_SUB, ALU_SBC: begin
                cin = (alu_instr_o.op == ALU_SBC) ? alu_flags_o.c : 1'b0;
                t9  = {1'b0, alu_instr_o.a} - {1'b0, alu_instr_o.b} - {8'h00, cin};
                t5  = {1'b0, alu_instr_o.a[3:0]} - {1'b0, alu_instr_o.b[3:0]} - {4'h0, cin};
                alu_out_i     = t9[7:0];
                alu_flags_i.z = (t9[7:0] == 8'h00);
                alu_flags_i.n = 1'b1;
                alu_flags_i.h = t5[4];
                alu_flags_i.c = t9[8];
            end
            default: begin
                alu_out_i = 8'h00;
            end
        endcase
    end

    // Monitor: compare every done pulse with the oldest expectation; ALU idle when not busy.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done cyc=%0d result=%h flags=%b", cyc, result, flags_o);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (cyc - e.acc != 3) begin
                    errors++;
                    $display("FAIL latency got=%0d want=3", cyc - e.acc);
                end
                checks++;
                if (result !== e.res) begin
                    errors++;
                    $display("FAIL result got=%h want=%h", result, e.res);
                end
                checks++;
                if (flags_o !== e.fl) begin
                    errors++;
                    $display("FAIL flags_o got=%b want=%b (znhc)", flags_o, e.fl);
                end
            end
        end
        if (!busy) begin
            checks++;
            if (alu_instr_o.op !== ALU_NOP || alu_instr_o.a !== 8'h00 ||
                alu_instr_o.b !== 8'h00 || alu_flags_o !== 4'b0000) begin
                errors++;
                $display("FAIL idle_alu_nop cyc=%0d got op=%0d a=%h b=%h f=%b", cyc,
                         alu_instr_o.op, alu_instr_o.a, alu_instr_o.b, alu_flags_o);
            end
        end
    end

    // One request per call; expects to be entered just after a falling edge.
    task automatic issue(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] f, input logic [15:0] er, input logic [3:0] ef);
        exp_t e;
        while (cyc < next_free) @(negedge clk);
        op        = o;
        operand_a = a;
        operand_b = b;
        flags_i   = f;
        start     = 1'b1;
        e.res = er;
        e.fl  = ef;
        e.acc = cyc;
        exp_q.push_back(e);
        next_free = cyc + 4;
        @(negedge clk);
        start     = 1'b0;
        flags_i   = ~f;
        operand_a = ~a;
        operand_b = ~b;
        op        = ~o;
    endtask

    task automatic check_eq(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    initial begin
        exp_t e;
        reset     = 1'b1;
        start     = 1'b0;
        op        = 2'b00;
        operand_a = 16'h0000;
        operand_b = 16'h0000;
        flags_i   = 4'b0000;
        repeat (3) @(negedge clk);
        check_eq("rst_busy",   {15'h0000, busy}, 16'h0000);
        check_eq("rst_done",   {15'h0000, done}, 16'h0000);
        check_eq("rst_result", result, 16'h0000);
        check_eq("rst_flags",  {12'h000, flags_o}, 16'h0000);
        reset = 1'b0;
        next_free = cyc;

        // op, a, b, flags_i(znhc), expected result, expected flags(znhc)
        issue(2'b00, 16'h0FFF, 16'h0001, 4'b1100, 16'h1000, 4'b1010);
        issue(2'b00, 16'hFFFF, 16'h0001, 4'b0100, 16'h0000, 4'b0011);
        issue(2'b00, 16'h8A23, 16'h8605, 4'b1000, 16'h1028, 4'b1011);
        issue(2'b01, 16'h0005, 16'h00FE, 4'b1100, 16'h0003, 4'b0011);
        issue(2'b01, 16'hFFF8, 16'hAB08, 4'b1111, 16'h0000, 4'b0011);
        issue(2'b01, 16'h1000, 16'h00FF, 4'b0000, 16'h0FFF, 4'b0000);
        issue(2'b10, 16'hFFFF, 16'h1234, 4'b0000, 16'h0000, 4'b0000);
        issue(2'b10, 16'h00FF, 16'h0000, 4'b0010, 16'h0100, 4'b0010);
        issue(2'b11, 16'h0000, 16'h5555, 4'b1111, 16'hFFFF, 4'b1111);

        // Back-to-back: start stays high; the second op is taken only once idle again.
        while (cyc < next_free) @(negedge clk);
        op        = 2'b00;
        operand_a = 16'h1234;
        operand_b = 16'h1111;
        flags_i   = 4'b0000;
        start     = 1'b1;
        e.res = 16'h2345; e.fl = 4'b0000; e.acc = cyc;
        exp_q.push_back(e);
        @(negedge clk);
        op        = 2'b11;
        operand_a = 16'h8000;
        operand_b = 16'h0000;
        flags_i   = 4'b0101;
        e.res = 16'h7FFF; e.fl = 4'b0101; e.acc = cyc + 3;
        exp_q.push_back(e);
        repeat (4) @(negedge clk);
        start     = 1'b0;
        flags_i   = 4'b1010;
        next_free = cyc + 3;

        // Reset during HI aborts the op: outputs clear and no done ever follows.
        while (cyc < next_free) @(negedge clk);
        op        = 2'b00;
        operand_a = 16'h0101;
        operand_b = 16'h0101;
        flags_i   = 4'b1111;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("abort_busy",   {15'h0000, busy}, 16'h0000);
        check_eq("abort_done",   {15'h0000, done}, 16'h0000);
        check_eq("abort_result", result, 16'h0000);
        check_eq("abort_flags",  {12'h000, flags_o}, 16'h0000);
        reset = 1'b0;
        next_free = cyc;

        issue(2'b00, 16'h7FFF, 16'h8001, 4'b0000, 16'h0000, 4'b0011);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        repeat (6) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
